hazard_scoreboard: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core: D, E, M, W.
- Generates the select codes consumed by the forwarding multiplexers, and the D-stage stall.
- Keeps its own shadow record of each in-flight instruction for the E, M and W stages: destination, read registers, Tnew and result source.
- Each record advances one stage per cycle alongside the datapath.

---
 rtl/hazard_scoreboard_if.sv | 92 +++++++++
 rtl/hazard_scoreboard.sv | 151 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
//
// Bundles the per-cycle signals between the core's D stage and the hazard
// scoreboard.
//
// Transfer rule: there is no valid/ready handshake. Every D-stage field,
// mdu_busy and flush are sampled on every rising clk edge. stall and the fw_*
// selects are combinational and are valid in the same cycle as the D fields.
//
// Signals:
//   d_rs, d_rt          D-stage source register addresses
//   d_tuse_rs/rt        cycles from D until each operand is consumed (all ones = unused)
//   d_a3                D-stage destination register (0 = no write)
//   d_tnew              cycles from E entry until the result exists
//   d_src               result source: 0 ALU, 1 MDU, 2 PC8, 3 MEM
//   d_mdu               D instruction uses the MDU
//   mdu_busy            MDU busy, or a start is issued in E
//   flush               exception/eret flush of the E and M records
//   stall               freeze PC and D register, insert a bubble into E
//   fw_d_rs, fw_d_rt    forwarding selects for the D operands
//   fw_e_rs, fw_e_rt    forwarding selects for the E operands
//   fw_m_rt             forwarding select for the M store data
//   stall_cnt           stall statistics counter (only when HAZ_STAT_EN is defined)
//
// Modports: master = the datapath side (drives D fields); slave = scoreboard.
//
// The select encodings normally come from def.v. They are defined here only
// if def.v has not been read first.

`ifndef FWSlen
`define FWSlen 3
`endif
`ifndef FW_orig
`define FW_orig 3'd0
`endif
`ifndef FW_EPC8
`define FW_EPC8 3'd1
`endif
`ifndef FW_MALU
`define FW_MALU 3'd2
`endif
`ifndef FW_MMDU
`define FW_MMDU 3'd3
`endif
`ifndef FW_MPC8
`define FW_MPC8 3'd4
`endif
`ifndef FW_W
`define FW_W 3'd5
`endif

interface hazard_scoreboard_if #(
    parameter int TNEW_W = 2
);
    logic [4:0]          d_rs;
    logic [4:0]          d_rt;
    logic [TNEW_W-1:0]   d_tuse_rs;
    logic [TNEW_W-1:0]   d_tuse_rt;
    logic [4:0]          d_a3;
    logic [TNEW_W-1:0]   d_tnew;
    logic [1:0]          d_src;
    logic                d_mdu;
    logic                mdu_busy;
    logic                flush;
    logic                stall;
    logic [`FWSlen-1:0]  fw_d_rs;
    logic [`FWSlen-1:0]  fw_d_rt;
    logic [`FWSlen-1:0]  fw_e_rs;
    logic [`FWSlen-1:0]  fw_e_rt;
    logic [`FWSlen-1:0]  fw_m_rt;
`ifdef HAZ_STAT_EN
    logic [31:0]         stall_cnt;
`endif

    modport master (
`ifdef HAZ_STAT_EN
        input  stall_cnt,
`endif
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew, d_src,
        output d_mdu, mdu_busy, flush,
        input  stall, fw_d_rs, fw_d_rt, fw_e_rs, fw_e_rt, fw_m_rt
    );

    modport slave (
`ifdef HAZ_STAT_EN
        output stall_cnt,
`endif
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew, d_src,
        input  d_mdu, mdu_busy, flush,
        output stall, fw_d_rs, fw_d_rt, fw_e_rs, fw_e_rt, fw_m_rt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Pipeline hazard controller for the 5-stage MIPS core. It keeps a shadow
// record (rs, rt, a3, tnew, src) for each instruction in E, M and W. The
// records advance one stage per cycle alongside the datapath. From them it
// derives:
//   - the D-stage stall, and
//   - the select codes used by the forwarding multiplexers.
//
// Ports:
//   clk    core clock
//   reset  synchronous, active-low reset (all records become bubbles)
//   hz     hazard_scoreboard_if.slave: D-stage fields, mdu_busy and flush in;
//          stall and fw_* selects out
//
// Optional feature: define HAZ_STAT_EN to add hz.stall_cnt. This 32-bit
// counter counts the cycles with stall=1 and flush=0. It wraps around and is
// cleared by reset.

module hazard_scoreboard #(
    parameter int TNEW_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave hz
);

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MDU = 2'd1;
    localparam logic [1:0] SRC_PC8 = 2'd2;

    typedef struct packed {
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        a3;
        logic [TNEW_W-1:0] tnew;
        logic [1:0]        src;
    } rec_t;

    localparam rec_t BUBBLE = '0;

    rec_t e_q, m_q, w_q;
    rec_t d_rec, e_adv, m_adv;
    logic stall;

    // A record blocks operand r if that record writes r and its result
    // arrives later than the consumer needs it. Register 0 never creates a
    // dependency.
    function automatic logic blocks(input logic [4:0] r,
                                    input logic [TNEW_W-1:0] tuse,
                                    input rec_t rec);
        return (r != 5'd0) && (rec.a3 == r) && (rec.tnew > tuse);
    endfunction

    // The nearest stage whose a3 matches r decides the select, so the
    // youngest producer always wins. A matching producer that is not ready
    // still claims the match and yields FW_orig; the stall logic covers that
    // case for D consumers.
    function automatic logic [`FWSlen-1:0] fw_sel(input logic [4:0] r,
                                                  input logic use_e,
                                                  input logic use_m,
                                                  input rec_t e,
                                                  input rec_t m,
                                                  input rec_t w);
        logic [`FWSlen-1:0] sel;
        sel = `FW_orig;
        if (r != 5'd0) begin
            if (use_e && (e.a3 == r)) begin
                // Only a PC8 result can already be ready in E.
                if (e.tnew == '0) sel = `FW_EPC8;
            end else if (use_m && (m.a3 == r)) begin
                // A load in M still has tnew=1, so it falls through to FW_orig.
                if (m.tnew == '0) begin
                    case (m.src)
                        SRC_ALU: sel = `FW_MALU;
                        SRC_MDU: sel = `FW_MMDU;
                        SRC_PC8: sel = `FW_MPC8;
                        default: sel = `FW_orig;
                    endcase
                end
            end else if (w.a3 == r) begin
                sel = `FW_W;
            end
        end
        return sel;
    endfunction

    always_comb begin
        d_rec      = BUBBLE;
        d_rec.rs   = hz.d_rs;
        d_rec.rt   = hz.d_rt;
        d_rec.a3   = hz.d_a3;
        d_rec.tnew = hz.d_tnew;
        d_rec.src  = hz.d_src;

        // E -> M: one cycle closer to the result, saturating at 0.
        e_adv = e_q;
        if (e_q.tnew != '0) e_adv.tnew = e_q.tnew - 1'b1;

        // M -> W: every result exists by W.
        m_adv      = m_q;
        m_adv.tnew = '0;
    end

    // W never stalls: its result is always available for forwarding.
    assign stall = blocks(hz.d_rs, hz.d_tuse_rs, e_q) ||
                   blocks(hz.d_rs, hz.d_tuse_rs, m_q) ||
                   blocks(hz.d_rt, hz.d_tuse_rt, e_q) ||
                   blocks(hz.d_rt, hz.d_tuse_rt, m_q) ||
                   (hz.d_mdu && hz.mdu_busy);

    assign hz.stall   = stall;
    assign hz.fw_d_rs = fw_sel(hz.d_rs, 1'b1, 1'b1, e_q, m_q, w_q);
    assign hz.fw_d_rt = fw_sel(hz.d_rt, 1'b1, 1'b1, e_q, m_q, w_q);
    assign hz.fw_e_rs = fw_sel(e_q.rs,  1'b0, 1'b1, e_q, m_q, w_q);
    assign hz.fw_e_rt = fw_sel(e_q.rt,  1'b0, 1'b1, e_q, m_q, w_q);
    assign hz.fw_m_rt = fw_sel(m_q.rt,  1'b0, 1'b0, e_q, m_q, w_q);

    // Priority: reset, then flush (beats stall), then normal advance.
    // A stall only swaps the incoming D record for a bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q <= BUBBLE;
            m_q <= BUBBLE;
            w_q <= BUBBLE;
        end else if (hz.flush) begin
            e_q <= BUBBLE;
            m_q <= BUBBLE;
            w_q <= m_q;
        end else begin
            e_q <= stall ? BUBBLE : d_rec;
            m_q <= e_adv;
            w_q <= m_adv;
        end
    end

`ifdef HAZ_STAT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall && !hz.flush) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//
// Directed scenarios for hazard_scoreboard: reset, load-use, ALU chain,
// jal/jr, youngest-producer selection, MDU forwarding and stalls, flush, and
// reset from a busy state. Each cycle pushes the expected
// {stall, fw_d_rs, fw_d_rt, fw_e_rs, fw_e_rt, fw_m_rt} vector to exp_q. The
// vector is popped and compared against the outputs 2 ns after the falling
// edge. Define HAZ_STAT_EN to also check the stall counter.

module tb_hazard_scoreboard;

    localparam logic [2:0] F_ORIG = 3'd0;
    localparam logic [2:0] F_EPC8 = 3'd1;
    localparam logic [2:0] F_MALU = 3'd2;
    localparam logic [2:0] F_MMDU = 3'd3;
    localparam logic [2:0] F_MPC8 = 3'd4;
    localparam logic [2:0] F_W    = 3'd5;

    logic clk;
    logic reset;

    hazard_scoreboard_if #(.TNEW_W(2)) hz();

    hazard_scoreboard #(.TNEW_W(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];
    int          n_cmp;
    int          n_err;
    int          step_no;
    int unsigned exp_stall_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL step %0d %s: got %0d expected %0d", step_no, tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] urs, input logic [1:0] urt,
                         input logic [4:0] a3, input logic [1:0] tnew,
                         input logic [1:0] src);
        hz.d_rs      = rs;
        hz.d_rt      = rt;
        hz.d_tuse_rs = urs;
        hz.d_tuse_rt = urt;
        hz.d_a3      = a3;
        hz.d_tnew    = tnew;
        hz.d_src     = src;
    endtask

    task automatic nop();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'd0);
    endtask

    // Called at a falling edge once the inputs are driven. It pushes the
    // expectation, compares at the sample point and returns at the next
    // falling edge.
    task automatic run(input logic st, input logic [2:0] f_drs, input logic [2:0] f_drt,
                       input logic [2:0] f_ers, input logic [2:0] f_ert,
                       input logic [2:0] f_mrt);
        logic [15:0] v;
        exp_q.push_back({st, f_drs, f_drt, f_ers, f_ert, f_mrt});
        #2;
        v = exp_q.pop_front();
        check("stall",   {31'd0, hz.stall},   {31'd0, v[15]});
        check("fw_d_rs", {29'd0, hz.fw_d_rs}, {29'd0, v[14:12]});
        check("fw_d_rt", {29'd0, hz.fw_d_rt}, {29'd0, v[11:9]});
        check("fw_e_rs", {29'd0, hz.fw_e_rs}, {29'd0, v[8:6]});
        check("fw_e_rt", {29'd0, hz.fw_e_rt}, {29'd0, v[5:3]});
        check("fw_m_rt", {29'd0, hz.fw_m_rt}, {29'd0, v[2:0]});
        if (!reset) exp_stall_cnt = 0;
        else if (st && !hz.flush) exp_stall_cnt++;
        step_no++;
        @(negedge clk);
    endtask

    task automatic check_cnt();
`ifdef HAZ_STAT_EN
        check("stall_cnt", hz.stall_cnt, exp_stall_cnt);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        step_no = 0;
        exp_stall_cnt = 0;
        reset = 1'b0;
        hz.d_mdu = 1'b0;
        hz.mdu_busy = 1'b0;
        hz.flush = 1'b0;
        nop();

        // Reset held for 2 cycles: empty records.
        repeat (2) @(posedge clk);
        @(negedge clk);
        run(0, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        reset = 1'b1;
        run(0, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        check_cnt();

        // Load-use: lw $8, then addu reading $8 stalls exactly once.
        set_d(5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 2'd2, 2'd3);
        run(0, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        set_d(5'd8, 5'd10, 2'd1, 2'd1, 5'd11, 2'd1, 2'd0);
        run(1, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        run(0, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        nop();
        run(0, F_ORIG, F_ORIG, F_W, F_ORIG, F_ORIG);

        // ALU chain: addu $9 consumed through rt without a stall.
        set_d(5'd11, 5'd0, 2'd1, 2'd3, 5'd9, 2'd1, 2'd0);
        run(0, F_MALU, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        set_d(5'd0, 5'd9, 2'd3, 2'd1, 5'd12, 2'd1, 2'd0);
        run(0, F_ORIG, F_ORIG, F_W, F_ORIG, F_ORIG);
        nop();
        run(0, F_ORIG, F_ORIG, F_ORIG, F_MALU, F_ORIG);

        // jal then jr $31. M store data ($9) comes from W here.
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 2'd2);
        run(0, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_W);
        set_d(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0);
        run(0, F_EPC8, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        run(0, F_MPC8, F_ORIG, F_MPC8, F_ORIG, F_ORIG);
        nop();
        run(0, F_ORIG, F_ORIG, F_W, F_ORIG, F_ORIG);

        // Youngest wins: mflo $5 then addu $5, consumer of $5.
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 2'd1);
        run(0, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 2'd0);
        run(0, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        set_d(5'd5, 5'd0, 2'd1, 2'd3, 5'd6, 2'd1, 2'd0);
        run(0, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        set_d(5'd5, 5'd0, 2'd2, 2'd3, 5'd0, 2'd0, 2'd0);
        run(0, F_MALU, F_ORIG, F_MALU, F_ORIG, F_ORIG);
        // Producer writing $0, then a reader of $0: no stall, no forward.
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 2'd3);
        run(0, F_ORIG, F_ORIG, F_W, F_ORIG, F_ORIG);
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 2'd0);
        run(0, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);

        // MDU result ($4) forwarded from M, then from W.
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1, 2'd1);
        run(0, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        nop();
        run(0, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        set_d(5'd4, 5'd4, 2'd0, 2'd0, 5'd0, 2'd0, 2'd0);
        run(0, F_MMDU, F_MMDU, F_ORIG, F_ORIG, F_ORIG);
        nop();
        run(0, F_ORIG, F_ORIG, F_W, F_W, F_ORIG);

        // MDU busy alone does not stall; with d_mdu it stalls 5 cycles.
        hz.mdu_busy = 1'b1;
        run(0, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        hz.d_mdu = 1'b1;
        for (int i = 0; i < 5; i++) run(1, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        hz.mdu_busy = 1'b0;
        run(0, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        hz.d_mdu = 1'b0;
        check_cnt();

        // Flush during a load-use stall: E/M become bubbles, W keeps old M.
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd13, 2'd1, 2'd0);
        run(0, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd2, 2'd3);
        run(0, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        set_d(5'd7, 5'd13, 2'd0, 2'd0, 5'd0, 2'd0, 2'd0);
        hz.flush = 1'b1;
        run(1, F_ORIG, F_MALU, F_ORIG, F_ORIG, F_ORIG);
        hz.flush = 1'b0;
        run(0, F_ORIG, F_W, F_ORIG, F_ORIG, F_ORIG);
        check_cnt();

        // Reset while a load sits in E.
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd2, 2'd3);
        run(0, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        set_d(5'd3, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0);
        reset = 1'b0;
        run(1, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        reset = 1'b1;
        run(0, F_ORIG, F_ORIG, F_ORIG, F_ORIG, F_ORIG);
        check_cnt();

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
